qdac_sequencer: RTL

Digital controller for the charge-redistribution QDAC analog island. It is the driving end of the island's frame pins: reset phase, code bus, and floating-gate programming controls (drain/gate address, enables, Prog/Run). It accepts conversion requests and FG-programming requests over two valid/ready ports and sequences the analog pins with cycle-exact phases. It sits between the system register/stream logic and the `tile_analog_frame` pins.

---
 rtl/qdac_pkg.sv | 31 +++
 rtl/qdac_phase_timer.sv | 28 ++
 rtl/qdac_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qdac_pkg.sv
// qdac_sequencer shared types and constants.
// Frame-pin reset levels live here so every stage agrees on them.
package qdac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV_RST,
    CONV_CODE,
    CONV_SETTLE,
    P_SETUP,
    P_PULSE,
    P_RECOVER
  } qdac_state_t;

  localparam int CODE_W_DEF       = 5;
  localparam int RST_CYCLES_DEF   = 4;
  localparam int SETTLE_W_DEF     = 8;
  localparam int SETUP_CYCLES_DEF = 2;
  localparam int PULSE_W_DEF      = 16;

  localparam logic DAC_RST_RV = 1'b1;
  localparam logic PROG_RV    = 1'b0;
  localparam logic RUN_RV     = 1'b1;
  localparam logic EN_RV      = 1'b0;

  function automatic int max2(input int a,
                              input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qdac_phase_timer.sv
// Loadable down-counter shared by every timed phase.
// Holds at zero; expire flags the last cycle of a phase.
module qdac_phase_timer
  import qdac_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         expire
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign expire = (value <= W'(1));

endmodule

// File: rtl/qdac_sequencer.sv
// Conversion / FG-programming sequencer for the QDAC frame pins.
// All pin outputs are registered from next-state values.
module qdac_sequencer
  import qdac_pkg::*;
#(
  parameter int CODE_W       = CODE_W_DEF,
  parameter int RST_CYCLES   = RST_CYCLES_DEF,
  parameter int SETTLE_W     = SETTLE_W_DEF,
  parameter int SETUP_CYCLES = SETUP_CYCLES_DEF,
  parameter int PULSE_W      = PULSE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [CODE_W-1:0]   s_code,
  input  logic [SETTLE_W-1:0] s_settle,
  input  logic                p_valid,
  output logic                p_ready,
  input  logic [3:0]          p_drain,
  input  logic [1:0]          p_gate,
  input  logic [PULSE_W-1:0]  p_len,
  output logic                dac_rst,
  output logic [CODE_W-1:0]   dac_code,
  output logic [3:0]          drain_b,
  output logic                drain_en,
  output logic [1:0]          gate_b,
  output logic                gate_en,
  output logic                prog,
  output logic                run,
  output logic                busy,
  output logic                s_done,
  output logic                p_done
);

  localparam int TW = max2(
    max2(PULSE_W, SETTLE_W),
    max2($clog2(RST_CYCLES + 1),
         $clog2(SETUP_CYCLES + 1)));

  localparam logic [TW-1:0] RST_LD   =
    TW'(RST_CYCLES);
  localparam logic [TW-1:0] SETUP_LD =
    TW'(SETUP_CYCLES);
  localparam logic [TW-1:0] ONE_LD   =
    TW'(1);

  qdac_state_t state_q;
  qdac_state_t state_d;

  logic [CODE_W-1:0]   code_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [3:0]          drain_q;
  logic [1:0]          gate_q;
  logic [PULSE_W-1:0]  len_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic [TW-1:0] tmr_value;
  logic [TW-1:0] tmr_nxt;
  logic          tmr_expire;
  logic          tmr_last_d;

  logic [TW-1:0] settle_ld;
  logic [TW-1:0] len_ld;

  logic s_acc;
  logic p_acc;

  logic              dac_rst_d;
  logic [CODE_W-1:0] code_d;
  logic [3:0]        drain_d;
  logic [1:0]        gate_d;
  logic              den_d;
  logic              gen_d;
  logic              prog_d;
  logic              run_d;
  logic              busy_d;
  logic              s_done_d;
  logic              p_done_d;
  logic [3:0]        drain_lat;
  logic [1:0]        gate_lat;

  assign p_ready = (state_q == IDLE) && !rst;
  assign s_ready = (state_q == IDLE) && !p_valid
                   && !rst;

  assign p_acc = p_valid && p_ready;
  assign s_acc = s_valid && s_ready;

  // zero-length requests still get one cycle
  assign settle_ld = (settle_q == '0) ?
    ONE_LD : TW'(settle_q);
  assign len_ld = (len_q == '0) ?
    ONE_LD : TW'(len_q);

  qdac_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  always_comb begin : fsm_next
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: begin
        if (p_acc) begin
          state_d  = P_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end else if (s_acc) begin
          state_d  = CONV_RST;
          tmr_load = 1'b1;
          tmr_val  = RST_LD;
        end
      end
      CONV_RST: begin
        if (tmr_expire) begin
          state_d = CONV_CODE;
        end
      end
      CONV_CODE: begin
        state_d  = CONV_SETTLE;
        tmr_load = 1'b1;
        tmr_val  = settle_ld;
      end
      CONV_SETTLE: begin
        if (tmr_expire) begin
          state_d = IDLE;
        end
      end
      P_SETUP: begin
        if (tmr_expire) begin
          state_d  = P_PULSE;
          tmr_load = 1'b1;
          tmr_val  = len_ld;
        end
      end
      P_PULSE: begin
        if (tmr_expire) begin
          state_d  = P_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      P_RECOVER: begin
        if (tmr_expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // look one cycle ahead so done pulses land on
  // the last cycle of their phase
  assign tmr_nxt = tmr_load ? tmr_val :
    ((tmr_value != '0) ? tmr_value - 1'b1 : '0);
  assign tmr_last_d = (tmr_nxt <= ONE_LD);

  assign drain_lat = p_acc ? p_drain : drain_q;
  assign gate_lat  = p_acc ? p_gate  : gate_q;

  always_comb begin : out_next
    dac_rst_d = dac_rst;
    code_d    = dac_code;
    drain_d   = '0;
    gate_d    = '0;
    den_d     = 1'b0;
    gen_d     = 1'b0;
    prog_d    = 1'b0;
    run_d     = 1'b1;
    unique case (state_d)
      CONV_RST: begin
        dac_rst_d = 1'b1;
        code_d    = '0;
      end
      CONV_CODE, CONV_SETTLE: begin
        dac_rst_d = 1'b0;
        code_d    = code_q;
      end
      P_SETUP, P_RECOVER: begin
        dac_rst_d = 1'b1;
        code_d    = '0;
        drain_d   = drain_lat;
        gate_d    = gate_lat;
        prog_d    = 1'b1;
        run_d     = 1'b0;
      end
      P_PULSE: begin
        dac_rst_d = 1'b1;
        code_d    = '0;
        drain_d   = drain_lat;
        gate_d    = gate_lat;
        den_d     = 1'b1;
        gen_d     = 1'b1;
        prog_d    = 1'b1;
        run_d     = 1'b0;
      end
      default: ;
    endcase
    busy_d   = (state_d != IDLE);
    s_done_d = (state_d == CONV_SETTLE)
               && tmr_last_d;
    p_done_d = (state_d == P_RECOVER)
               && tmr_last_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      dac_rst  <= DAC_RST_RV;
      dac_code <= '0;
      drain_b  <= '0;
      gate_b   <= '0;
      drain_en <= EN_RV;
      gate_en  <= EN_RV;
      prog     <= PROG_RV;
      run      <= RUN_RV;
      busy     <= 1'b0;
      s_done   <= 1'b0;
      p_done   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dac_rst  <= dac_rst_d;
      dac_code <= code_d;
      drain_b  <= drain_d;
      gate_b   <= gate_d;
      drain_en <= den_d;
      gate_en  <= gen_d;
      prog     <= prog_d;
      run      <= run_d;
      busy     <= busy_d;
      s_done   <= s_done_d;
      p_done   <= p_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q   <= '0;
      settle_q <= '0;
      drain_q  <= '0;
      gate_q   <= '0;
      len_q    <= '0;
    end else begin
      if (s_acc) begin
        code_q   <= s_code;
        settle_q <= s_settle;
      end
      if (p_acc) begin
        drain_q <= p_drain;
        gate_q  <= p_gate;
        len_q   <= p_len;
      end
    end
  end

endmodule
